// File: rtl/fwrisc_trace_pkg.sv
// Shared trace record type and constants for the FWRISC trace capture block.
// FWRISC_TRACE_TIMESTAMP_EN adds a 32-bit cycle timestamp field to each record.
package fwrisc_trace_pkg;

    localparam logic [5:0] TEMP_REG_ADDR = 6'h3f;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_v;
        logic [5:0]  rd_addr;
        logic [31:0] rd_data;
        logic        mem_v;
        logic        mem_we;
        logic [3:0]  mem_strb;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
`ifdef FWRISC_TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } trace_rec_t;

    localparam int TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/fwrisc_trace_fifo.sv
// Generic synchronous FIFO with registered storage and first-word output.
// A separate level counter tells full from empty; a push while full is accepted only alongside a pop.
module fwrisc_trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_level   = r_level;
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || i_pop);

    // Empty output reads as zero so the record port is clean out of reset.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/fwrisc_trace_capture.sv
// Folds tracer-port activity into one record per retired instruction and queues it for a sink.
// FWRISC_TRACE_TIMESTAMP_EN stamps each record with a free-running 32-bit cycle count.
module fwrisc_trace_capture
    import fwrisc_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic [31:0]              instr,
    input  logic                     ivalid,
    input  logic [5:0]               rd_waddr,
    input  logic [31:0]              rd_wdata,
    input  logic                     rd_write,
    input  logic [31:0]              maddr,
    input  logic [31:0]              mdata,
    input  logic [3:0]               mstrb,
    input  logic                     mwrite,
    input  logic                     mvalid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TRACE_REC_W-1:0]   out_rec,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    logic        r_mem_v;
    logic        r_mem_we;
    logic [3:0]  r_mem_strb;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data;
    logic        r_rd_v;
    logic [5:0]  r_rd_addr;
    logic [31:0] r_rd_data;
    logic        r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    logic        w_rd_ok;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_drop;
    trace_rec_t  w_rec;

    // The core's TEMP register is scratch state, never architectural write-back.
    assign w_rd_ok = rd_write && (rd_waddr != TEMP_REG_ADDR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_v    <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_strb <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_rd_v     <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
        end else if (ivalid) begin
            r_mem_v    <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_strb <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_rd_v     <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
        end else begin
            if (mvalid) begin
                r_mem_v    <= 1'b1;
                r_mem_we   <= mwrite;
                r_mem_strb <= mstrb;
                r_mem_addr <= maddr;
                r_mem_data <= mdata;
            end
            if (w_rd_ok) begin
                r_rd_v    <= 1'b1;
                r_rd_addr <= rd_waddr;
                r_rd_data <= rd_wdata;
            end
        end
    end

`ifdef FWRISC_TRACE_TIMESTAMP_EN
    logic [31:0] r_ts;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end
`endif

    // Same-cycle activity overrides whatever was pending from earlier cycles.
    always_comb begin
        w_rec       = '0;
        w_rec.pc    = pc;
        w_rec.instr = instr;
        if (w_rd_ok) begin
            w_rec.rd_v    = 1'b1;
            w_rec.rd_addr = rd_waddr;
            w_rec.rd_data = rd_wdata;
        end else begin
            w_rec.rd_v    = r_rd_v;
            w_rec.rd_addr = r_rd_addr;
            w_rec.rd_data = r_rd_data;
        end
        if (mvalid) begin
            w_rec.mem_v    = 1'b1;
            w_rec.mem_we   = mwrite;
            w_rec.mem_strb = mstrb;
            w_rec.mem_addr = maddr;
            w_rec.mem_data = mdata;
        end else begin
            w_rec.mem_v    = r_mem_v;
            w_rec.mem_we   = r_mem_we;
            w_rec.mem_strb = r_mem_strb;
            w_rec.mem_addr = r_mem_addr;
            w_rec.mem_data = r_mem_data;
        end
`ifdef FWRISC_TRACE_TIMESTAMP_EN
        w_rec.ts = r_ts;
`endif
    end

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_drop    = ivalid && w_full && !w_pop;

    fwrisc_trace_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (ivalid),
        .i_pop   (w_pop),
        .i_data  (w_rec),
        .o_data  (out_rec),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fwrisc_trace_capture.sv
// Directed bench for fwrisc_trace_capture: record folding, TEMP filtering, backpressure, drops and reset.
module tb_fwrisc_trace_capture;
    import fwrisc_trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [31:0]            pc = '0;
    logic [31:0]            instr = '0;
    logic                   ivalid = 1'b0;
    logic [5:0]             rd_waddr = '0;
    logic [31:0]            rd_wdata = '0;
    logic                   rd_write = 1'b0;
    logic [31:0]            maddr = '0;
    logic [31:0]            mdata = '0;
    logic [3:0]             mstrb = '0;
    logic                   mwrite = 1'b0;
    logic                   mvalid = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [TRACE_REC_W-1:0] out_rec;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_cnt;
    logic [LVL_W-1:0]       level;

    trace_rec_t  rec;
    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    assign rec = out_rec;

    always #5 clock = ~clock;

    fwrisc_trace_capture #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .ivalid    (ivalid),
        .rd_waddr  (rd_waddr),
        .rd_wdata  (rd_wdata),
        .rd_write  (rd_write),
        .maddr     (maddr),
        .mdata     (mdata),
        .mstrb     (mstrb),
        .mwrite    (mwrite),
        .mvalid    (mvalid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rec   (out_rec),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ivalid   = 1'b0;
        rd_write = 1'b0;
        mvalid   = 1'b0;
        mwrite   = 1'b0;
        rd_waddr = '0;
        rd_wdata = '0;
        maddr    = '0;
        mdata    = '0;
        mstrb    = '0;
    endtask

    // One-cycle retire with no write-back or memory activity in the same cycle.
    task automatic retire_plain(input logic [31:0] p);
        pc     = p;
        instr  = 32'h0000_0013;
        ivalid = 1'b1;
        step();
        ivalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", out_valid); end
        n_tests++; if (out_rec !== '0) begin n_fail++; $display("FAIL reset_rec: got %h exp 0", out_rec); end
        n_tests++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d exp 0", level); end
        n_tests++; if (overflow !== 1'b0 || drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop: got ovf=%0b cnt=%0d exp 0/0", overflow, drop_cnt); end
        @(posedge clock); #1;
        reset = 1'b1;
        step();
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        pc       = 32'h0000_0100;
        instr    = 32'h0050_0093;
        rd_write = 1'b1;
        rd_waddr = 6'd1;
        rd_wdata = 32'd5;
        ivalid   = 1'b1;
        step();
        idle_inputs();
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0b exp 1", out_valid); end
        n_tests++; if (rec.pc !== 32'h100 || rec.instr !== 32'h0050_0093) begin n_fail++; $display("FAIL addi_pc: got pc=%h instr=%h exp 100/00500093", rec.pc, rec.instr); end
        n_tests++; if (rec.rd_v !== 1'b1 || rec.rd_addr !== 6'd1 || rec.rd_data !== 32'd5) begin n_fail++; $display("FAIL addi_rd: got v=%0b a=%0d d=%h exp 1/1/5", rec.rd_v, rec.rd_addr, rec.rd_data); end
        n_tests++; if (rec.mem_v !== 1'b0) begin n_fail++; $display("FAIL addi_memv: got %0b exp 0", rec.mem_v); end
        step();
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL addi_drain: got valid=%0b level=%0d exp 0/0", out_valid, level); end
    endtask

    task automatic test_store();
        out_ready = 1'b1;
        // An earlier access is overwritten by the later one before retire.
        mvalid = 1'b1; mwrite = 1'b0; maddr = 32'h0000_1111; mdata = 32'h1; mstrb = 4'h1;
        step();
        mvalid = 1'b1; mwrite = 1'b1; maddr = 32'h0000_2000; mdata = 32'hDEAD_BEEF; mstrb = 4'hF;
        step();
        idle_inputs();
        step();
        retire_plain(32'h0000_0104);
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b1 || rec.pc !== 32'h104) begin n_fail++; $display("FAIL store_rec: got valid=%0b pc=%h exp 1/104", out_valid, rec.pc); end
        n_tests++; if (rec.mem_v !== 1'b1 || rec.mem_we !== 1'b1 || rec.mem_strb !== 4'hF) begin n_fail++; $display("FAIL store_ctl: got v=%0b we=%0b strb=%h exp 1/1/f", rec.mem_v, rec.mem_we, rec.mem_strb); end
        n_tests++; if (rec.mem_addr !== 32'h2000 || rec.mem_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_data: got a=%h d=%h exp 2000/deadbeef", rec.mem_addr, rec.mem_data); end
        n_tests++; if (rec.rd_v !== 1'b0) begin n_fail++; $display("FAIL store_rdv: got %0b exp 0", rec.rd_v); end
        retire_plain(32'h0000_0108);
        @(negedge clock);
        n_tests++; if (rec.pc !== 32'h108 || rec.mem_v !== 1'b0) begin n_fail++; $display("FAIL store_next: got pc=%h mem_v=%0b exp 108/0", rec.pc, rec.mem_v); end
        step();
    endtask

    task automatic test_temp_and_x0();
        out_ready = 1'b1;
        rd_write = 1'b1; rd_waddr = TEMP_REG_ADDR; rd_wdata = 32'h1234;
        step();
        idle_inputs();
        retire_plain(32'h0000_010C);
        @(negedge clock);
        n_tests++; if (rec.pc !== 32'h10C || rec.rd_v !== 1'b0) begin n_fail++; $display("FAIL temp_filter: got pc=%h rd_v=%0b exp 10c/0", rec.pc, rec.rd_v); end
        pc = 32'h0000_0110; instr = 32'h0550_0013;
        rd_write = 1'b1; rd_waddr = 6'd0; rd_wdata = 32'h55; ivalid = 1'b1;
        step();
        idle_inputs();
        @(negedge clock);
        n_tests++; if (rec.rd_v !== 1'b1 || rec.rd_addr !== 6'd0 || rec.rd_data !== 32'h55) begin n_fail++; $display("FAIL x0_write: got v=%0b a=%0d d=%h exp 1/0/55", rec.rd_v, rec.rd_addr, rec.rd_data); end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        int          seen;
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i < DEPTH) exp_q.push_back(32'h1000 + 32'(i * 4));
            retire_plain(32'h1000 + 32'(i * 4));
        end
        @(negedge clock);
        n_tests++; if (level !== LVL_W'(DEPTH)) begin n_fail++; $display("FAIL bp_level: got %0d exp %0d", level, DEPTH); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %0b exp 1", overflow); end
        n_tests++; if (drop_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL bp_drop_cnt: got %0d exp 3", drop_cnt); end
        n_tests++; if (rec.pc !== 32'h1000) begin n_fail++; $display("FAIL bp_stable_head: got %h exp 1000", rec.pc); end
        @(posedge clock); #1;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 4 * DEPTH && exp_q.size() != 0; k++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                got = exp_q.pop_front();
                seen++;
                n_tests++; if (rec.pc !== got) begin n_fail++; $display("FAIL bp_order: got %h exp %h", rec.pc, got); end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_timeout: got %0d records exp %0d", seen, DEPTH); end
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL bp_extra: got valid=%0b level=%0d exp 0/0", out_valid, level); end
        @(posedge clock); #1;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] got;
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) exp_q.push_back(32'h2000 + 32'(i * 4));
            retire_plain(32'h2000 + 32'(i * 4));
        end
        exp_q.push_back(32'h0000_F000);
        out_ready = 1'b1;
        pc = 32'h0000_F000; instr = 32'h0000_0013; ivalid = 1'b1;
        step();
        idle_inputs();
        out_ready = 1'b0;
        @(negedge clock);
        n_tests++; if (level !== LVL_W'(DEPTH)) begin n_fail++; $display("FAIL fpp_level: got %0d exp %0d", level, DEPTH); end
        n_tests++; if (drop_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL fpp_drop_cnt: got %0d exp 3", drop_cnt); end
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && exp_q.size() != 0; k++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                got = exp_q.pop_front();
                n_tests++; if (rec.pc !== got) begin n_fail++; $display("FAIL fpp_order: got %h exp %h", rec.pc, got); end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fpp_timeout: got %0d left exp 0", exp_q.size()); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) retire_plain(32'h3000 + 32'(i * 4));
        mvalid = 1'b1; mwrite = 1'b1; maddr = 32'h4000; mdata = 32'h77; mstrb = 4'h3;
        step();
        idle_inputs();
        @(negedge clock);
        n_tests++; if (level !== LVL_W'(4)) begin n_fail++; $display("FAIL rst_pre_level: got %0d exp 4", level); end
        reset = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL rst_async: got valid=%0b level=%0d exp 0/0", out_valid, level); end
        n_tests++; if (overflow !== 1'b0 || drop_cnt !== '0) begin n_fail++; $display("FAIL rst_async_drop: got ovf=%0b cnt=%0d exp 0/0", overflow, drop_cnt); end
        @(posedge clock); #1;
        reset = 1'b1;
        step();
        step();
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_stale: got %0b exp 0", out_valid); end
        @(posedge clock); #1;
        retire_plain(32'h0000_5000);
        @(negedge clock);
        n_tests++; if (out_valid !== 1'b1 || rec.pc !== 32'h5000 || level !== LVL_W'(1)) begin n_fail++; $display("FAIL rst_fresh: got valid=%0b pc=%h level=%0d exp 1/5000/1", out_valid, rec.pc, level); end
        n_tests++; if (rec.mem_v !== 1'b0) begin n_fail++; $display("FAIL rst_pending_clr: got mem_v=%0b exp 0", rec.mem_v); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_temp_and_x0();
        test_backpressure();
        test_full_push_pop();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwrisc_trace_capture.md
Name: fwrisc_trace_capture

Overview:
- Sits directly downstream of the core's tracer port bundle, in parallel with the formal arithmetic checker.
- Folds each retired instruction into one record: PC, instruction, rd write-back and any memory access since the previous retire.
- Buffers records in a FIFO and drains them over a valid/ready stream to a trace sink (sim log writer or formal cover harness).
- Loses no record silently: drops are counted and flagged.

Parameters:
DEPTH, 8, FIFO entries; power of two, >=2
CNT_W, 16, width of the dropped-record counter

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
pc  in  32  PC of the executing instruction
instr  in  32  instruction word
ivalid  in  1  execute/retire strobe; write-back may coincide
rd_waddr  in  6  destination register address
rd_wdata  in  32  write-back data
rd_write  in  1  write-back strobe
maddr  in  32  memory address
mdata  in  32  memory data
mstrb  in  4  byte strobes
mwrite  in  1  1 = store
mvalid  in  1  memory access strobe
out_valid  out  1  record available
out_ready  in  1  sink accepts record
out_rec  out  TRACE_REC_W  packed fwrisc_trace_pkg::trace_rec_t
overflow  out  1  sticky: at least one record dropped
drop_cnt  out  CNT_W  dropped-record count; saturates at all-ones
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset==0, asynchronous): FIFO empty, out_valid=0, out_rec=0, overflow=0, drop_cnt=0, level=0, pending-access and pending-write-back registers cleared.
- Pending access: on mvalid && !ivalid, latch maddr/mdata/mstrb/mwrite and set mem_v.
  - A second mvalid before retire overwrites; the last access wins.
- Pending write-back: rd_write with !ivalid latches rd_waddr/rd_wdata and sets rd_v.
  - rd_waddr==6'h3f is the core TEMP register. Ignore it: it is never latched and never sets rd_v.
- Retire: on ivalid, build the record from pc, instr, and the pending fields.
  - Same-cycle rd_write or mvalid takes priority over pending values.
  - Pending state clears in the same clock edge.
- Record latency: ivalid in cycle N, record written at edge N+1.
  - If the FIFO was empty, out_valid=1 in cycle N+1 with that record.
  - No combinational path from any input to out_valid or out_rec.
- FIFO: first-word registered output.
  - Pop when out_valid && out_ready.
  - out_rec stays stable while out_valid && !out_ready.
- Full handling:
  - Push when full with no simultaneous pop: record dropped, overflow<=1, drop_cnt increments, saturating.
  - Full with simultaneous pop and push: both occur, no drop, level unchanged.
- Pointers: $clog2(DEPTH)-bit read/write pointers wrap modulo DEPTH; a separate level counter disambiguates full from empty.
- Write to x0 (rd_waddr==0 with rd_write): recorded as-is with rd_v=1. The sink flags it; this block does not filter it.
- Reset asserted mid-stream: all contents discarded immediately; first record after release comes only from a fresh ivalid.

Optional Feature:
FWRISC_TRACE_TIMESTAMP_EN
- Defined:
  - 32-bit free-running cycle counter, reset to 0, incrementing every clock and wrapping at 2^32.
  - Counter value in the ivalid cycle is stored in the record's ts field.
  - TRACE_REC_W grows by 32.
- Undefined: no counter; ts field absent from trace_rec_t.

Decomposition:
- fwrisc_trace_pkg holds:
  - trace_rec_t packed struct: pc, instr, rd_v, rd_addr, rd_data, mem_v, mem_we, mem_strb, mem_addr, mem_data, and ts under the macro.
  - TRACE_REC_W constant.
  - TEMP_REG_ADDR = 6'h3f.
- Sub-module fwrisc_trace_fifo: generic width/DEPTH sync FIFO.
  - Ports: push, pop, data in/out, full, empty, level.
  - Capture logic stays in fwrisc_trace_capture.

Test Plan:
- Single ADDI: pc=0x100, instr=0x00500093, rd_write rd=1 data=5 with ivalid, out_ready=1 -> one cycle later out_valid=1 with rd_v=1, rd_addr=1, rd_data=5, mem_v=0.
- Store then retire: mvalid, mwrite=1, maddr=0x2000, mdata=0xDEADBEEF, mstrb=0xF; two cycles later ivalid -> record has mem_v=1, mem_we=1 and those values; next record has mem_v=0.
- TEMP filter: rd_write to 0x3f with value 0x1234, then ivalid with no write -> rd_v=0.
- Backpressure: out_ready=0, DEPTH+3 retires -> level=DEPTH, overflow=1, drop_cnt=3; release ready -> exactly DEPTH records, in order, first DEPTH PCs.
- Full with simultaneous push and pop at level=DEPTH -> no drop, drop_cnt unchanged, level stays DEPTH.
- Reset pulse (reset=0 for 1 cycle) with 4 records queued -> out_valid=0, level=0, overflow=0 immediately; next ivalid yields a fresh record.
